keypad_entry_conditioner: RTL and testbench

Front-end stage for the password lock: conditions the ten raw digit switches into clean, one-hot digit events for the password-checking FSM directly downstream. Synchronizes and debounces `sw_raw`, then accepts exactly one event per physical press. A press is accepted only if exactly one key is down. It holds the accepted one-hot code on `key_code` for the checker, reports chorded presses, and flags an abandoned partial entry through an inter-digit timeout.

---
 rtl/keypad_entry_conditioner.sv | 178 +++++++++++++++++
 tb/tb_keypad_entry_conditioner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_entry_conditioner
//  Purpose  : Synchronizes and debounces ten raw digit switches. Emits one
//             clean one-hot digit event per physical press, flags chorded
//             presses, and raises an inter-digit timeout for abandoned entry.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_entry_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sw_raw,
    output logic [9:0] key_code,
    output logic [3:0] digit,
    output logic       key_valid,
    output logic       multi_key,
    output logic       entry_timeout,
    output logic       busy
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [9:0]       sw_meta;
    logic [9:0]       sw_s;
    logic [9:0]       snap;
    logic [CNT_W-1:0] cnt;
    logic [TMR_W-1:0] tmr;
    logic             armed;

    logic             snap_load;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             accept;
    logic             chord;
    logic             one_hot;
    logic [3:0]       digit_enc;

    // Two-flop synchronizer; everything downstream looks only at sw_s.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= sw_raw;
            sw_s    <= sw_meta;
        end
    end

    // Snapshot qualification: exactly one bit set, and its binary index.
    always_comb begin
        one_hot   = (snap != 10'd0) && ((snap & (snap - 10'd1)) == 10'd0);
        digit_enc = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (snap[i]) begin
                digit_enc = 4'(i);
            end
        end
    end

    // Next-state logic and per-cycle control strobes for the debounce FSM.
    always_comb begin
        state_next = state;
        snap_load  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        accept     = 1'b0;
        chord      = 1'b0;
        case (state)
            IDLE: begin
                if (sw_s != 10'd0) begin
                    snap_load  = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (sw_s != snap) begin
                    state_next = IDLE;
                end else if (cnt == CNT_MAX) begin
                    accept     = one_hot;
                    chord      = !one_hot;
                    state_next = HELD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HELD: begin
                // Pattern changes while held (extra keys) are deliberately ignored.
                if (sw_s == 10'd0) begin
                    cnt_clr    = 1'b1;
                    state_next = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                if (sw_s != 10'd0) begin
                    state_next = HELD;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, debounce counter, snapshot and registered key outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snap      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            digit     <= '0;
            key_valid <= 1'b0;
            multi_key <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            key_valid <= accept;
            multi_key <= chord;
            busy      <= (state_next != IDLE);
            if (snap_load) begin
                snap <= sw_s;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (accept) begin
                key_code <= snap;
                digit    <= digit_enc;
            end
        end
    end

    // Inter-digit timer: an accept reloads it, which also beats a same-cycle expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed         <= 1'b0;
            tmr           <= '0;
            entry_timeout <= 1'b0;
        end else begin
            entry_timeout <= 1'b0;
            if (accept) begin
                armed <= 1'b1;
                tmr   <= '0;
            end else if (armed) begin
                if (tmr == TMR_MAX) begin
                    entry_timeout <= 1'b1;
                    armed         <= 1'b0;
                end else begin
                    tmr <= tmr + TMR_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_entry_conditioner
//  Purpose  : Directed self-checking bench for keypad_entry_conditioner with
//             DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=64.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_conditioner;

    localparam int DEB = 4;
    localparam int TMO = 64;

    logic       clk;
    logic       rst;
    logic [9:0] sw_raw;
    logic [9:0] key_code;
    logic [3:0] digit;
    logic       key_valid;
    logic       multi_key;
    logic       entry_timeout;
    logic       busy;

    int checks;
    int errors;
    int cyc;

    int         kv_total;
    int         kv_cyc;
    int         mk_total;
    int         mk_cyc;
    int         to_total;
    int         to_cyc;
    logic [9:0] kv_log [64];

    keypad_entry_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sw_raw        (sw_raw),
        .key_code      (key_code),
        .digit         (digit),
        .key_valid     (key_valid),
        .multi_key     (multi_key),
        .entry_timeout (entry_timeout),
        .busy          (busy)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: after posedge n, cyc == n.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Event recorder on the falling edge: pulse counts, edge of last pulse, code log.
    always @(negedge clk) begin
        if (key_valid) begin
            kv_total <= kv_total + 1;
            kv_cyc   <= cyc;
            if (kv_total < 64) kv_log[kv_total] <= key_code;
        end
        if (multi_key) begin
            mk_total <= mk_total + 1;
            mk_cyc   <= cyc;
        end
        if (entry_timeout) begin
            to_total <= to_total + 1;
            to_cyc   <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Return 1 time unit after posedge e.
    task automatic go_to(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        kv_total = 0;
        kv_cyc   = -1;
        mk_total = 0;
        mk_cyc   = -1;
        to_total = 0;
        to_cyc   = -1;
        rst      = 1'b1;
        sw_raw   = 10'd0;

        // Reset state
        go_to(3);
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_multi_key", 32'(multi_key), 32'd0);
        check("rst_timeout", 32'(entry_timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Clean press of digit 3 first sampled at edge 10, held 50 cycles
        go_to(9);
        sw_raw = 10'd8;
        go_to(60);
        check("d3_kv_count", 32'(kv_total), 32'd1);
        check("d3_kv_edge", 32'(kv_cyc), 32'd16);
        check("d3_key_code", 32'(key_code), 32'd8);
        check("d3_digit", 32'(digit), 32'd3);
        check("d3_busy_held", 32'(busy), 32'd1);
        sw_raw = 10'd0;
        go_to(90);
        check("d3_busy_idle", 32'(busy), 32'd0);
        check("d3_to_count", 32'(to_total), 32'd1);
        check("d3_to_edge", 32'(to_cyc), 32'd80);

        // Press bounce: 2-cycle toggles, then digit 0 stable from edge 120
        for (int i = 0; i < 10; i++) begin
            go_to(99 + 2 * i);
            sw_raw = (i % 2 == 0) ? 10'd1 : 10'd0;
        end
        go_to(119);
        sw_raw = 10'd1;
        go_to(139);
        check("bnc_kv_count", 32'(kv_total), 32'd2);
        check("bnc_kv_edge", 32'(kv_cyc), 32'd126);
        check("bnc_key_code", 32'(key_code), 32'd1);
        check("bnc_digit", 32'(digit), 32'd0);
        // Release bounce of two cycles, then a clean release at edge 155
        sw_raw = 10'd0;
        go_to(141);
        sw_raw = 10'd1;
        go_to(154);
        sw_raw = 10'd0;
        go_to(175);
        check("rbnc_kv_count", 32'(kv_total), 32'd2);
        check("rbnc_mk_count", 32'(mk_total), 32'd0);
        check("rbnc_busy", 32'(busy), 32'd0);
        go_to(200);
        check("bnc_to_edge", 32'(to_cyc), 32'd190);
        check("bnc_to_count", 32'(to_total), 32'd2);

        // Chord of digits 2 and 4 first sampled at edge 210
        go_to(209);
        sw_raw = 10'b0000010100;
        go_to(230);
        check("chord_mk_count", 32'(mk_total), 32'd1);
        check("chord_mk_edge", 32'(mk_cyc), 32'd216);
        check("chord_kv_count", 32'(kv_total), 32'd2);
        check("chord_key_code", 32'(key_code), 32'd1);
        check("chord_digit", 32'(digit), 32'd0);
        sw_raw = 10'd0;

        // Password 8,1,2,4 (one-hot codes of digits 3,0,1,2), presses at 250/270/290/310
        for (int j = 0; j < 4; j++) begin
            go_to(249 + 20 * j);
            sw_raw = (j == 0) ? 10'd8 : (j == 1) ? 10'd1 : (j == 2) ? 10'd2 : 10'd4;
            go_to(259 + 20 * j);
            sw_raw = 10'd0;
        end
        go_to(400);
        check("seq_kv_count", 32'(kv_total), 32'd6);
        check("seq_code0", 32'(kv_log[2]), 32'd8);
        check("seq_code1", 32'(kv_log[3]), 32'd1);
        check("seq_code2", 32'(kv_log[4]), 32'd2);
        check("seq_code3", 32'(kv_log[5]), 32'd4);
        check("seq_last_kv_edge", 32'(kv_cyc), 32'd316);
        check("seq_to_count", 32'(to_total), 32'd3);
        check("seq_to_edge", 32'(to_cyc), 32'd380);

        // Timeout race: accept at 416 expires at 480, second accept lands at 480
        go_to(409);
        sw_raw = 10'd32;
        go_to(419);
        sw_raw = 10'd0;
        go_to(473);
        sw_raw = 10'd64;
        go_to(483);
        sw_raw = 10'd0;
        go_to(500);
        check("race_kv_count", 32'(kv_total), 32'd8);
        check("race_kv_edge", 32'(kv_cyc), 32'd480);
        check("race_digit", 32'(digit), 32'd6);
        check("race_no_timeout", 32'(to_total), 32'd3);
        go_to(560);
        check("race_to_count", 32'(to_total), 32'd4);
        check("race_to_edge", 32'(to_cyc), 32'd544);

        // Reset while HELD with digit 1 still down
        go_to(579);
        sw_raw = 10'd2;
        go_to(590);
        check("pre_rst_digit", 32'(digit), 32'd1);
        rst = 1'b1;
        go_to(591);
        check("midrst_key_code", 32'(key_code), 32'd0);
        check("midrst_digit", 32'(digit), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_key_valid", 32'(key_valid), 32'd0);
        go_to(592);
        rst = 1'b0;
        go_to(620);
        check("postrst_kv_count", 32'(kv_total), 32'd10);
        check("postrst_kv_edge", 32'(kv_cyc), 32'd599);
        check("postrst_digit", 32'(digit), 32'd1);
        check("postrst_key_code", 32'(key_code), 32'd2);
        check("postrst_busy", 32'(busy), 32'd1);
        go_to(655);
        check("postrst_timer_cleared", 32'(to_total), 32'd4);
        go_to(670);
        check("postrst_to_count", 32'(to_total), 32'd5);
        check("postrst_to_edge", 32'(to_cyc), 32'd663);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
